// File: rtl/xf_pkg.sv
// Shared definitions for the matrix row fetcher: FSM state encoding and a
// constant-evaluable ceil(log2) helper for sizing counters and ports.
package xf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/matrix_row_bank.sv
// Shadow rows collect returning beats; a commit copies the masked rows into the
// committed view in one edge so consumers never observe a partial matrix.
module matrix_row_bank
  import xf_pkg::*;
#(
  parameter int ROWS_MAX = 4,
  parameter int DATA_W   = 128,
  parameter int RW       = clog2(ROWS_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [RW-1:0]              wr_row,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       commit,
  input  logic [ROWS_MAX-1:0]        row_mask,
  output logic [ROWS_MAX*DATA_W-1:0] rows_out
);

  logic [DATA_W-1:0] shadow    [ROWS_MAX];
  logic [DATA_W-1:0] committed [ROWS_MAX];

  always_ff @(posedge clk) begin
    for (int k = 0; k < ROWS_MAX; k++) begin
      if (wr_en && (wr_row == RW'(k))) shadow[k] <= wr_data;
    end
  end

  // The final beat lands in the same edge as the commit, so it bypasses the shadow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < ROWS_MAX; k++) committed[k] <= '0;
    end else if (commit) begin
      for (int k = 0; k < ROWS_MAX; k++) begin
        if (row_mask[k]) begin
          committed[k] <= (wr_en && (wr_row == RW'(k))) ? wr_data : shadow[k];
        end
      end
    end
  end

  always_comb begin
    rows_out = '0;
    for (int k = 0; k < ROWS_MAX; k++) rows_out[k*DATA_W +: DATA_W] = committed[k];
  end

endmodule

// File: rtl/matrix_row_fetcher.sv
// Fetches up to ROWS_MAX strided rows from a latency-tolerant memory port and
// publishes them atomically on matrix_out with a one-cycle done pulse.
module matrix_row_fetcher
  import xf_pkg::*;
#(
  parameter int ROWS_MAX = 4,
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 7,
  parameter int STRIDE_W = 3
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [clog2(ROWS_MAX+1)-1:0]   req_rows,
  input  logic [STRIDE_W-1:0]            req_stride,
  output logic [ADDR_W-1:0]              mp_addr,
  output logic                           mp_enable,
  input  logic [DATA_W-1:0]              mp_data,
  input  logic                           mp_valid,
  output logic [ROWS_MAX*DATA_W-1:0]     matrix_out,
  output logic                           done,
  output logic                           busy,
  output logic                           err_spurious
);

  localparam int RW = clog2(ROWS_MAX + 1);

  fetch_state_t state, state_nxt;

  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   stride_r;
  logic [ADDR_W-1:0]   eff_stride;
  logic [RW-1:0]       rows_r, rows_clamp;
  logic [RW-1:0]       iss_cnt, ret_cnt, out_cnt, out_nxt;
  logic [ROWS_MAX-1:0] row_mask;
  logic                accept, issue, ret, spurious, last_issue, last_ret;
  logic                done_r, err_r;

  always_comb begin
    accept     = (state == IDLE) && req_valid;
    issue      = (state == ISSUE);
    spurious   = mp_valid && (out_cnt == '0);
    ret        = mp_valid && !spurious;
    last_issue = issue && (iss_cnt == rows_r - RW'(1));
    last_ret   = ret && (ret_cnt == rows_r - RW'(1));
    out_nxt    = out_cnt + RW'(issue) - RW'(ret);
    eff_stride = (req_stride == '0) ? ADDR_W'(1) : ADDR_W'(req_stride);
    rows_clamp = ((req_rows == '0) || (req_rows > RW'(ROWS_MAX))) ? RW'(ROWS_MAX) : req_rows;
    for (int k = 0; k < ROWS_MAX; k++) row_mask[k] = (RW'(k) < rows_r);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        if (last_ret)        state_nxt = IDLE;
        else if (last_issue) state_nxt = (out_nxt != '0) ? DRAIN : IDLE;
      end
      DRAIN: if (last_ret) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      iss_cnt <= '0;
      ret_cnt <= '0;
      out_cnt <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      out_cnt <= out_nxt;
      done_r  <= last_ret;
      if (spurious) err_r <= 1'b1;
      if (accept) begin
        iss_cnt <= '0;
        ret_cnt <= '0;
      end else begin
        if (issue) iss_cnt <= iss_cnt + RW'(1);
        if (ret)   ret_cnt <= ret_cnt + RW'(1);
      end
    end
  end

  // Request parameters only matter once a fetch has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_addr <= req_addr;
      stride_r <= eff_stride;
      rows_r   <= rows_clamp;
    end else if (issue) begin
      cur_addr <= cur_addr + stride_r;
    end
  end

  matrix_row_bank #(
    .ROWS_MAX (ROWS_MAX),
    .DATA_W   (DATA_W),
    .RW       (RW)
  ) u_bank (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (ret),
    .wr_row   (ret_cnt),
    .wr_data  (mp_data),
    .commit   (last_ret),
    .row_mask (row_mask),
    .rows_out (matrix_out)
  );

  assign req_ready    = (state == IDLE);
  assign busy         = (state != IDLE);
  assign mp_enable    = issue;
  assign mp_addr      = cur_addr;
  assign done         = done_r;
  assign err_spurious = err_r;

endmodule
